ir_pi_seq: RTL and testbench

- Parametrised IR line-sensor sequencer with a built-in PI steering loop.
- Cycles through NUM_PAIRS IR emitter pairs. For each pair it settles, converts the inner and outer channels through the external A2D handshake, and accumulates a position-weighted error.
- Computes P and I compensation with internal arithmetic (no external ALU) and emits saturated left and right motor commands.
- Sits between the A2D interface and the motor PWM drivers.

---
 rtl/ir_pi_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_ir_pi_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ir_pi_seq.sv
// ir_pi_seq -- IR line-sensor sequencer with a built-in PI steering loop.
//
// Scans NUM_PAIRS emitter/sensor pairs. For each pair it settles the
// emitter, converts the inner and then the outer channel through the
// external A2D handshake, and accumulates a position-weighted error
// (inner adds, outer subtracts, both scaled by 2^k). Once per loop it
// computes P and I terms with internal multipliers and emits saturated
// left/right motor commands.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   go              run enable; low forces IDLE and clears loop state
//   cnv_cmplt       A2D conversion done (only sampled in CNV_IN/CNV_OUT)
//   A2D_res[11:0]   A2D result, unsigned
//   strt_cnv        one-cycle A2D start pulse
//   chnnl[2:0]      A2D channel select (held from strt_cnv to cnv_cmplt)
//   ir_en[NP-1:0]   PWM emitter enable, only the active pair's bit toggles
//   LEDs[7:0]       Error[11:4]
//   lft/rht[10:0]   motor commands, lft_reg[11:1] / rht_reg[11:1]
//   out_vld         one-cycle pulse when lft/rht carry a new value
//
// Optional feature: define IR_PI_SEQ_ANTI_WINDUP_EN to freeze the
// integrator update whenever the previous loop's RHT or LFT saturated.
//
// PTERM and ITERM are gain magnitudes: they are zero-extended before the
// signed multiply, so a positive Error always steers lft above rht.
module ir_pi_seq #(
  parameter int          NUM_PAIRS  = 3,
  parameter int          SETTLE_CYC = 4096,
  parameter int          GAP_CYC    = 32,
  parameter logic [23:0] CHN_MAP    = 24'h03B501,
  parameter logic [7:0]  IR_DUTY    = 8'h8C,
  parameter logic [13:0] PTERM      = 14'h3680,
  parameter logic [11:0] ITERM      = 12'h500,
  parameter int          INT_DEC    = 4,
  parameter logic [11:0] FWD_MAX    = 12'h700
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 cnv_cmplt,
  input  logic [11:0]          A2D_res,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  output logic [NUM_PAIRS-1:0] ir_en,
  output logic [7:0]           LEDs,
  output logic [10:0]          lft,
  output logic [10:0]          rht,
  output logic                 out_vld
);

  localparam int TMAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IDW  = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;

  typedef enum logic [3:0] {
    IDLE, SETTLE, CNV_IN, GAP, CNV_OUT,
    ERR, INTG, ICMP1, ICMP2, PCMP1, PCMP2, RHT, LFT
  } state_t;

  function automatic logic signed [11:0] sat12(input logic signed [19:0] v);
    if (v > 20'sd2047)       return 12'sh7FF;
    else if (v < -20'sd2048) return 12'sh800;
    else                     return v[11:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [19:0] v);
    if (v > 20'sd32767)       return 16'sh7FFF;
    else if (v < -20'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  state_t                state, nxt;
  logic                  strt_nxt;
  logic [TW-1:0]         tmr;
  logic [1:0]            k;
  logic [7:0]            pwm_cnt;
  logic                  pwm, pair_on, last_pair;
  logic [15:0]           a2d_shift;
  logic signed [15:0]    accum;
  logic signed [11:0]    error, intgrl, icomp;
  logic signed [15:0]    pcomp;
  logic [11:0]           fwd;
  logic [IDW-1:0]        int_dec;
  logic                  int_wrap, intg_hold;
  logic signed [24:0]    iprod;
  logic signed [26:0]    pprod;
  logic signed [11:0]    lft_reg, rht_reg;
  logic signed [19:0]    sum_r, sum_l, intg_sum;
  logic                  unused_ok;

  assign pwm       = (pwm_cnt < IR_DUTY);
  assign pair_on   = (state == SETTLE) || (state == CNV_IN) ||
                     (state == GAP)    || (state == CNV_OUT);
  assign last_pair = (k == 2'(NUM_PAIRS-1));
  assign a2d_shift = 16'({4'd0, A2D_res} << k);
  assign int_wrap  = (int_dec == IDW'(INT_DEC-1));
  assign intg_sum  = 20'(intgrl) + 20'(error >>> 4);
  assign sum_r     = $signed({8'd0, fwd}) - 20'(pcomp) - 20'(icomp);
  assign sum_l     = $signed({8'd0, fwd}) + 20'(pcomp) + 20'(icomp);

  assign LEDs      = error[11:4];
  assign lft       = lft_reg[11:1];
  assign rht       = rht_reg[11:1];
  assign unused_ok = ^{lft_reg[0], rht_reg[0]};

  // Channel select: slot {k, sel} indexes CHN_MAP; outer slot in GAP/CNV_OUT.
  always_comb begin
    logic [2:0] slot;
    chnnl = 3'd0;
    slot  = {k, (state == GAP) || (state == CNV_OUT)};
    if (pair_on)
      for (int s = 0; s < 8; s++)
        if (slot == 3'(s)) chnnl = CHN_MAP[3*s +: 3];
  end

  for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_ir
    assign ir_en[i] = pair_on && pwm && (k == 2'(i));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt      = state;
    strt_nxt = 1'b0;
    if (!go) nxt = IDLE;
    else begin
      case (state)
        IDLE:    nxt = SETTLE;
        SETTLE:  if (tmr == TW'(SETTLE_CYC-1)) begin nxt = CNV_IN; strt_nxt = 1'b1; end
        CNV_IN:  if (cnv_cmplt) nxt = GAP;
        GAP:     if (tmr == TW'(GAP_CYC-1)) begin nxt = CNV_OUT; strt_nxt = 1'b1; end
        CNV_OUT: if (cnv_cmplt) nxt = last_pair ? ERR : SETTLE;
        ERR:     nxt = INTG;
        INTG:    nxt = ICMP1;
        ICMP1:   nxt = ICMP2;
        ICMP2:   nxt = PCMP1;
        PCMP1:   nxt = PCMP2;
        PCMP2:   nxt = RHT;
        RHT:     nxt = LFT;
        LFT:     nxt = SETTLE;
        default: nxt = IDLE;
      endcase
    end
  end

`ifdef IR_PI_SEQ_ANTI_WINDUP_EN
  // Remembers whether either motor command clipped in the most recent loop.
  logic sat_last, rht_sat, lft_sat;
  assign rht_sat = (sum_r != 20'(sat12(sum_r)));
  assign lft_sat = (sum_l != 20'(sat12(sum_l)));

  always_ff @(posedge clk or posedge rst)
    if (rst)                 sat_last <= 1'b0;
    else if (!go)            sat_last <= 1'b0;
    else if (state == RHT)   sat_last <= rht_sat;
    else if (state == LFT)   sat_last <= sat_last | lft_sat;

  assign intg_hold = sat_last;
`else
  assign intg_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strt_cnv <= 1'b0;
      out_vld  <= 1'b0;
      tmr      <= '0;
      k        <= '0;
      pwm_cnt  <= '0;
      accum    <= '0;
      error    <= '0;
      intgrl   <= '0;
      icomp    <= '0;
      pcomp    <= '0;
      fwd      <= '0;
      int_dec  <= '0;
      iprod    <= '0;
      pprod    <= '0;
      lft_reg  <= '0;
      rht_reg  <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 8'd1;
      strt_cnv <= strt_nxt;
      out_vld  <= 1'b0;
      tmr      <= (nxt != state) ? '0 : tmr + TW'(1);
      if (!go) begin
        // Dropping go abandons the loop: any pending result is never added.
        fwd     <= '0;
        intgrl  <= '0;
        int_dec <= '0;
        lft_reg <= '0;
        rht_reg <= '0;
      end else begin
        case (state)
          IDLE: begin
            accum <= '0;
            k     <= '0;
          end
          CNV_IN:  if (cnv_cmplt) accum <= accum + a2d_shift;
          CNV_OUT: if (cnv_cmplt) begin
            accum <= accum - a2d_shift;
            if (!last_pair) k <= k + 2'd1;
          end
          ERR:   error <= sat12(20'(accum));
          INTG: begin
            int_dec <= int_wrap ? '0 : int_dec + IDW'(1);
            if (int_wrap) begin
              if (!intg_hold) intgrl <= sat12(intg_sum);
              if (fwd < FWD_MAX) fwd <= fwd + 12'd1;
            end
          end
          ICMP1: iprod <= 25'(intgrl) * 25'($signed({1'b0, ITERM}));
          ICMP2: icomp <= sat12(20'(iprod >>> 12));
          PCMP1: pprod <= 27'(error) * 27'($signed({1'b0, PTERM}));
          PCMP2: pcomp <= sat16(20'(pprod >>> 12));
          RHT:   rht_reg <= sat12(sum_r);
          LFT: begin
            lft_reg <= sat12(sum_l);
            out_vld <= 1'b1;
            accum   <= '0;
            k       <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_pi_seq.sv
// Directed bench for ir_pi_seq (SETTLE_CYC=16, GAP_CYC=4, other params default).
// A small A2D model answers each strt_cnv after a2d_dly cycles; the main
// initial block walks through reset, balanced scan, saturated error,
// go-drop and stalled conversion scenarios with hand-computed expectations.
module tb_ir_pi_seq;
  logic        clk = 1'b0;
  logic        rst, go, cnv_cmplt;
  logic [11:0] A2D_res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [2:0]  ir_en;
  logic [7:0]  LEDs;
  logic [10:0] lft, rht;
  logic        out_vld;

  ir_pi_seq #(.SETTLE_CYC(16), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst), .go(go), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .ir_en(ir_en), .LEDs(LEDs),
    .lft(lft), .rht(rht), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // A2D model controls/state
  int         a2d_dly = 5;
  bit         a2d_en = 1'b1;
  int         mode = 0;          // 0: every channel 0x100, 1: only ch3 = 0x200
  bit         man_cmplt = 1'b0;
  int         cnt = 0;
  logic [2:0] cap_ch = 3'd0;
  int         n_strt = 0;
  int         last_cmplt = 0;
  bit         proto_bad = 1'b0;
  bit         prev_strt = 1'b0;
  logic [2:0] chq[$];
  logic [2:0] exp_ch[6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  function automatic logic [11:0] resp(input logic [2:0] ch, input int m);
    if (m == 0) return 12'h100;
    return (ch == 3'd3) ? 12'h200 : 12'h000;
  endfunction

  initial begin
    cnv_cmplt = 1'b0;
    A2D_res   = 12'h000;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (!a2d_en) cnt = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (chnnl !== cap_ch) proto_bad = 1'b1;
          A2D_res    = resp(cap_ch, mode);
          cnv_cmplt  = 1'b1;
          last_cmplt = cyc;
        end
      end
      if (strt_cnv === 1'b1) begin
        if (prev_strt) proto_bad = 1'b1;
        n_strt++;
        chq.push_back(chnnl);
        cap_ch = chnnl;
        cnt    = a2d_dly;
      end
      prev_strt = (strt_cnv === 1'b1);
      if (man_cmplt) cnv_cmplt = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input string tag, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (out_vld === 1'b1) ok = 1'b1;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_strt(input string tag, input logic [2:0] ch, input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (strt_cnv === 1'b1 && chnnl === ch) ok = 1'b1;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int n0, bad, hi;
    logic [31:0] exp_int;

    // Reset with go high and random cnv_cmplt
    rst = 1'b1; go = 1'b1;
    repeat (6) begin @(negedge clk); man_cmplt = 1'($urandom_range(0, 1)); end
    @(negedge clk);
    chk("reset_ctl", {strt_cnv, chnnl, ir_en, out_vld, LEDs}, 32'd0);
    chk("reset_cmd", {lft, rht}, 32'd0);

    // Release reset with go low: stay idle
    go = 1'b0; man_cmplt = 1'b0;
    @(negedge clk); rst = 1'b0;
    n0 = n_strt; bad = 0;
    repeat (20) begin @(negedge clk); if (ir_en !== 3'd0 || strt_cnv !== 1'b0) bad++; end
    chk("idle_quiet", bad, 0);
    chk("idle_nstrt", n_strt - n0, 0);

    // Balanced scan: Error 0, lft == rht == Fwd>>1, Fwd = loops/4
    chq.delete(); n0 = n_strt;
    go = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      wait_vld("bal_vld", 400);
      chk("bal_latency", cyc - last_cmplt, 9);
      chk("bal_lft_eq_rht", {21'd0, lft}, {21'd0, rht});
      chk("bal_lft", {21'd0, lft}, (n / 4) >> 1);
      chk("bal_leds", {24'd0, LEDs}, 0);
      if (n == 1) begin
        chk("bal_nstrt", n_strt - n0, 6);
        for (int i = 0; i < 6; i++) chk("chn_seq", {29'd0, chq[i]}, {29'd0, exp_ch[i]});
      end
    end

    // Only ch3 (pair 2 inner) answers 0x200: Accum 0x800 -> Error 0x7FF
    mode = 1;
    for (int n = 1; n <= 72; n++) begin
      wait_vld("sat_vld", 400);
      if (n == 1) begin
        chk("sat_leds", {24'd0, LEDs}, 32'h7F);
        chk("sat_lft", {21'd0, lft}, 32'h3FF);
        chk("sat_rht", {21'd0, rht}, 32'h400);
        chk("sat_lft_gt_rht", {31'd0, ($signed(lft) > $signed(rht))}, 32'd1);
      end
    end
    chk("sat_lft_end", {21'd0, lft}, 32'h3FF);
`ifdef IR_PI_SEQ_ANTI_WINDUP_EN
    exp_int = 32'h000;
`else
    exp_int = 32'h7FF;
`endif
    chk("intgrl", {20'd0, dut.intgrl}, exp_int);

    // Drop go during CNV_IN of pair 1 (channel 4)
    mode = 0;
    wait_vld("pre_drop_vld", 400);
    wait_strt("drop_find_ch4", 3'd4, 400);
    a2d_en = 1'b0;
    repeat (2) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("drop_ctl", {strt_cnv, ir_en, out_vld, chnnl}, 32'd0);
    chk("drop_cmd", {lft, rht}, 32'd0);
    man_cmplt = 1'b1;
    repeat (2) @(negedge clk);
    man_cmplt = 1'b0;
    n0 = n_strt; bad = 0;
    repeat (30) begin @(negedge clk); if (ir_en !== 3'd0 || out_vld !== 1'b0) bad++; end
    chk("drop_ignore", bad, 0);
    chk("drop_nstrt", n_strt - n0, 0);

    // Restart at pair 0 with a 300-cycle conversion stall
    a2d_en = 1'b1; a2d_dly = 300;
    go = 1'b1;
    wait_strt("restart_ch1", 3'd1, 100);
    n0 = n_strt; hi = 0; bad = 0;
    repeat (256) begin
      @(negedge clk);
      if (ir_en[0] === 1'b1) hi++;
      if (ir_en[2:1] !== 2'd0) bad++;
    end
    chk("stall_duty", hi, 140);
    chk("stall_nstrt", n_strt - n0, 0);
    chk("stall_other_en", bad, 0);
    chk("stall_chnnl", {29'd0, chnnl}, 32'd1);
    a2d_dly = 5;
    wait_vld("post_vld", 600);
    chk("post_latency", cyc - last_cmplt, 9);
    chk("post_cmd", {lft, rht}, 32'd0);
    chk("protocol", {31'd0, proto_bad}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
